// File: rtl/iiitb_imem_loader.sv
// iiitb_imem_loader: byte-serial program loader and instruction fetch port.
// Receives a COUNT / data / CHK frame over a valid-ready byte stream. It packs
// little-endian words into instruction memory starting at word 0 and checks the
// trailing checksum. The core is held in reset until a frame loads cleanly.
module iiitb_imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          core_rst,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [AW:0] WC_ONE = {{AW{1'b0}}, 1'b1};

    state_t      state_q,    state_d;
    logic [AW:0] count_q,    count_d;
    logic [AW:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  acc_q,      acc_d;
    logic [23:0] asm_q,      asm_d;
    logic        in_ready_q, in_ready_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;

    // Instruction storage; deliberately not reset so a reload simply overwrites it.
    logic [31:0] mem_q [DEPTH];

    logic          accept_s;
    logic          count_ok_s;
    logic [8:0]    in_ext_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [31:0]   wdata_s;

    // Handshake qualifies on the registered ready, so DONE/ERR ignore the stream.
    assign accept_s   = in_valid && in_ready_q;
    assign in_ext_s   = {1'b0, in_data};
    assign count_ok_s = (in_data != 8'd0) && (in_ext_s <= 9'(DEPTH));

    // Next-state, word assembly, checksum and output-flag decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        asm_d      = asm_q;
        we_s       = 1'b0;
        waddr_s    = word_cnt_q[AW-1:0];
        wdata_s    = {in_data, asm_q};

        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (count_ok_s) begin
                        count_d    = in_ext_s[AW:0];
                        byte_idx_d = 2'd0;
                        acc_d      = in_data;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d    = ST_ERR;
                    end
                end
                ST_LOAD: begin
                    acc_d      = acc_q + in_data;
                    asm_d      = {in_data, asm_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_s       = 1'b1;
                        word_cnt_d = word_cnt_q + WC_ONE;
                        if ((word_cnt_q + WC_ONE) == count_q) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_CHK: begin
                    if (in_data == acc_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CHK);
        core_rst_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    // State and control registers, cleared asynchronously by RN.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= 2'd0;
            acc_q      <= 8'd0;
            asm_q      <= 24'd0;
            in_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            asm_q      <= asm_d;
            in_ready_q <= in_ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Word write on the edge that accepts the fourth byte of each word.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Fetch is only visible after a verified load and for in-range addresses.
    always_comb begin
        fetch_instr = 32'h0;
        if (done_q && (fetch_addr < 32'(DEPTH))) begin
            fetch_instr = mem_q[fetch_addr[AW-1:0]];
        end else begin
            fetch_instr = 32'h0;
        end
    end

    assign in_ready  = in_ready_q;
    assign core_rst  = core_rst_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_iiitb_imem_loader.sv
// Scoreboard bench for iiitb_imem_loader: stimulus pushes expected status per
// accepted byte and expected probe results; monitors pop and compare.
module tb_iiitb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          RN = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic [31:0]   fetch_addr = 32'h0;
    logic [31:0]   fetch_instr;
    logic          core_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          is_fetch;
    } exp_t;

    exp_t hs_q[$];
    exp_t pr_q[$];
    exp_t hs_e;
    exp_t pr_e;
    logic [7:0] hs_byte;

    always #5 clk = ~clk;

    iiitb_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .RN          (RN),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .core_rst    (core_rst),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_cnt    (word_cnt)
    );

    function automatic logic [31:0] st(input bit rdy, input bit crst, input bit done,
                                       input bit err, input int wc);
        logic [5:0] w;
        w = wc[5:0];
        return {22'd0, rdy, crst, done, err, w};
    endfunction

    function automatic logic [31:0] status_now();
        return {22'd0, in_ready, core_rst, load_done, load_err, word_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake monitor: every accepted byte must match the next queued status.
    always @(posedge clk) begin
        if (!RN && in_valid && in_ready) begin
            hs_byte = in_data;
            #1;
            if (hs_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept: got byte %h accepted expected no transfer", hs_byte);
            end else begin
                hs_e = hs_q.pop_front();
                check(hs_e.name, status_now(), hs_e.exp);
            end
        end
    end

    // Probe monitor: compares queued fetch/status expectations mid-cycle.
    always @(negedge clk) begin
        if (pr_q.size() != 0) begin
            pr_e = pr_q.pop_front();
            if (pr_e.is_fetch) begin
                check(pr_e.name, fetch_instr, pr_e.exp);
            end else begin
                check(pr_e.name, status_now(), pr_e.exp);
            end
        end
    end

    task automatic push_q(input bit to_hs, input string name, input logic [31:0] exp, input bit is_fetch);
        exp_t e;
        e.name     = name;
        e.exp      = exp;
        e.is_fetch = is_fetch;
        if (to_hs) hs_q.push_back(e);
        else       pr_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe_fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
        fetch_addr = addr;
        push_q(1'b0, name, exp, 1'b1);
        step();
    endtask

    task automatic probe_status(input string name, input logic [31:0] exp);
        push_q(1'b0, name, exp, 1'b0);
        step();
    endtask

    task automatic do_reset();
        RN = 1'b1;
        probe_status("reset_state", st(1'b1, 1'b1, 1'b0, 1'b0, 0));
        RN = 1'b0;
    endtask

    task automatic send(input string name, input logic [7:0] b, input logic [31:0] exp);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        push_q(1'b1, name, exp, 1'b0);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            if (in_ready === 1'b1) got = 1'b1;
        end
        #2;
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            hs_q.delete(hs_q.size() - 1);
            $display("FAIL %s_timeout: got no accept expected byte accepted", name);
        end
    endtask

    task automatic send_ignored(input logic [7:0] b, input int cycles);
        in_valid = 1'b1;
        in_data  = b;
        repeat (cycles) step();
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input string tag, input logic [7:0] fr[$], input bit good, input int stall_at);
        int n;
        n = int'(fr[0]);
        send({tag, "_count"}, fr[0], st(1'b1, 1'b1, 1'b0, 1'b0, 0));
        for (int k = 1; k < fr.size() - 1; k++) begin
            send($sformatf("%s_d%0d", tag, k - 1), fr[k], st(1'b1, 1'b1, 1'b0, 1'b0, k / 4));
            if (k == stall_at) begin
                probe_status({tag, "_stalled"}, st(1'b1, 1'b1, 1'b0, 1'b0, k / 4));
                repeat (4) step();
            end
        end
        if (good) send({tag, "_chk"}, fr[fr.size() - 1], st(1'b0, 1'b0, 1'b1, 1'b0, n));
        else      send({tag, "_chk"}, fr[fr.size() - 1], st(1'b0, 1'b1, 1'b0, 1'b1, n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] f1[$];
        logic [7:0] fb[$];
        logic [7:0] ff[$];
        logic [7:0] ib;

        f1 = '{8'h02, 8'h00, 8'h84, 8'h32, 8'h02, 8'h80, 8'h93, 8'h42, 8'h02, 8'h11};
        fb = f1;
        fb[9] = 8'h12;
        ff.push_back(8'h20);
        for (int i = 0; i < 32; i++) begin
            ib = 8'(i);
            ff.push_back(8'h00);
            ff.push_back(ib);
            ff.push_back(8'h00);
            ff.push_back(8'h00);
        end
        ff.push_back(8'h10);

        step();

        // Good two-word load
        do_reset();
        load_frame("good", f1, 1'b1, -1);
        probe_fetch("good_a0", 32'd0, 32'h02328400);
        probe_fetch("good_a1", 32'd1, 32'h02429380);
        probe_fetch("good_a40", 32'd40, 32'h0);
        probe_fetch("good_a32", 32'd32, 32'h0);
        send_ignored(8'h55, 3);
        probe_status("done_hold", st(1'b0, 1'b0, 1'b1, 1'b0, 2));
        probe_fetch("done_hold_a1", 32'd1, 32'h02429380);

        // Bad checksum
        do_reset();
        probe_fetch("rst_hidden_a0", 32'd0, 32'h0);
        load_frame("badchk", fb, 1'b0, -1);
        probe_fetch("err_a0", 32'd0, 32'h0);
        probe_fetch("err_a1", 32'd1, 32'h0);
        send_ignored(8'h02, 3);
        probe_status("err_hold", st(1'b0, 1'b1, 1'b0, 1'b1, 2));

        // Illegal COUNT values
        do_reset();
        send("cnt00", 8'h00, st(1'b0, 1'b1, 1'b0, 1'b1, 0));
        send_ignored(8'h01, 2);
        probe_status("cnt00_hold", st(1'b0, 1'b1, 1'b0, 1'b1, 0));
        do_reset();
        send("cnt21", 8'h21, st(1'b0, 1'b1, 1'b0, 1'b1, 0));

        // Full-depth load
        do_reset();
        load_frame("full", ff, 1'b1, -1);
        probe_fetch("full_a31", 32'd31, 32'h00001F00);
        probe_fetch("full_a5", 32'd5, 32'h00000500);
        probe_fetch("full_a1", 32'd1, 32'h00000100);
        probe_fetch("full_a32", 32'd32, 32'h0);

        // Stalled stream
        do_reset();
        load_frame("stall", f1, 1'b1, 2);
        probe_fetch("stall_a0", 32'd0, 32'h02328400);
        probe_fetch("stall_a1", 32'd1, 32'h02429380);

        // Reset in the middle of a load, then a full reload
        do_reset();
        send("mid_count", f1[0], st(1'b1, 1'b1, 1'b0, 1'b0, 0));
        for (int k = 1; k <= 6; k++) begin
            send($sformatf("mid_d%0d", k - 1), f1[k], st(1'b1, 1'b1, 1'b0, 1'b0, k / 4));
        end
        do_reset();
        probe_fetch("mid_hidden_a0", 32'd0, 32'h0);
        load_frame("reload", f1, 1'b1, -1);
        probe_fetch("reload_a0", 32'd0, 32'h02328400);
        probe_fetch("reload_a1", 32'd1, 32'h02429380);

        repeat (3) step();
        total++;
        if (hs_q.size() != 0 || pr_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", hs_q.size(), pr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iiitb_imem_loader.md
# iiitb_imem_loader

Byte-serial instruction-memory loader and fetch port for the iiitb_rv32i core. It accepts a framed program over a valid/ready byte stream, assembles little-endian 32-bit words into a DEPTH×32 instruction memory from address 0, and verifies a trailing checksum. It holds the core in reset until the load completes, then serves combinational instruction reads addressed by the core's NPC.

## Interface
- DEPTH, 32, instruction memory depth in words; legal 1..255
- AW, 5, index width, equal to clog2(DEPTH)
- clk  in  1  rising-edge clock
- RN  in  1  reset; asynchronous, active-high
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader can accept a byte
- fetch_addr  in  32  word address from the core (NPC)
- fetch_instr  out  32  instruction at fetch_addr
- core_rst  out  1  reset to the core; high until a good load completes
- load_done  out  1  program loaded and checksum matched
- load_err  out  1  frame rejected
- word_cnt  out  AW+1  number of words written so far

## Operation
- Frame format: COUNT byte N, then 4·N data bytes, each word LSB first, then a CHK byte.
- CHK must equal (COUNT + all data bytes) mod 256, 8-bit wrap.
- A byte transfers on a rising clk edge where in_valid && in_ready.
- States:
  - IDLE: awaiting COUNT. Accepting a COUNT of 1..DEPTH latches N, clears the byte index and checksum accumulator, and moves to LOAD. A COUNT of 0 or >DEPTH moves to ERR.
  - LOAD: shifts bytes into a 32-bit assembly register. On the 4th byte, writes {b3,b2,b1,b0} to mem[word_cnt] and increments word_cnt. After word N is written, moves to CHK.
  - CHK: accepting the CHK byte moves to DONE on a match, otherwise to ERR.
  - DONE and ERR: terminal; left only via RN.
- in_ready = 1 in IDLE, LOAD and CHK; 0 in DONE and ERR. It is decoded from registered state only.
- Checksum accumulator adds every accepted byte except CHK, including COUNT.
- fetch_instr is combinational:
  - mem[fetch_addr[AW-1:0]] when load_done=1 and fetch_addr < DEPTH;
  - 32'h0 otherwise, including while loading and in ERR.
- Writes are not gated by the fetch port. Fetch is never active during load because core_rst is high.
- Memory contents are not cleared by RN. Unwritten words past N read as stale data; software loads full programs.

## Timing
- Reset values, asynchronous on RN rising or high: state=IDLE, in_ready=1, core_rst=1, load_done=0, load_err=0, word_cnt=0, byte index=0, accumulator=0.
- Word write latency: mem updates on the edge accepting that word's 4th byte. A fetch of that address sees it combinationally after load_done.
- DONE entry, core_rst falling and load_done rising all occur on the edge accepting a matching CHK byte. The core leaves reset that cycle.
- ERR entry and load_err rising occur on the edge accepting a bad COUNT or mismatched CHK. core_rst stays 1.
- word_cnt counts up to N and saturates there. It holds its value in DONE and ERR.
- in_valid with in_ready=0 (DONE/ERR) is ignored. No state or memory change occurs.
- in_valid low mid-word: the partial word is held indefinitely. There is no timeout.
- RN asserted mid-load: immediate return to IDLE. Words already written remain in mem but are unreadable until a new frame completes.
- N=DEPTH: the last write is to mem[DEPTH-1]. word_cnt reaches DEPTH, which needs AW+1 bits.

## Test plan
- Good 2-word load. Bytes 02, 00 84 32 02, 80 93 42 02, CHK 11.
  - Required: mem[0]=32'h02328400, mem[1]=32'h02429380, load_done=1.
  - core_rst falls on the CHK edge; in_ready=0 afterwards.
  - fetch_addr=1 gives 32'h02429380; fetch_addr=40 gives 32'h0.
- Bad checksum: same frame with CHK 12.
  - Required: load_err=1, core_rst=1, load_done=0, fetch_instr=0 for all addresses, further bytes ignored.
- Illegal COUNT 00, and separately 21 with DEPTH=32.
  - Required: ERR on the first byte, word_cnt=0.
- Full load: COUNT 20 (32 words), word i = 32'h0000_0100·i, correct CHK.
  - Required: word_cnt=32, mem[31]=32'h00001F00, done.
- Stalled stream: drop in_valid for 5 cycles after byte 2 of word 0, then resume.
  - Required: identical result to the first scenario.
- Reset mid-load: assert RN after 6 data bytes, then send the full first-scenario frame.
  - Required: in_ready=1, core_rst=1, word_cnt=0 immediately; the later frame completes correctly.
